// File: rtl/tilt_decoder_if.sv
// tilt_decoder_if: accelerometer samples in, filtered values and
// committed tilt direction out.
interface tilt_decoder_if;
  logic signed [11:0] acc_x;
  logic signed [11:0] acc_y;
  logic signed [11:0] acc_z;
  logic signed [11:0] filt_x;
  logic signed [11:0] filt_y;
  logic [2:0]         dir;
  logic               dir_valid;
  logic               ready;

  modport master (
    output acc_x, acc_y, acc_z,
    input  filt_x, filt_y, dir, dir_valid, ready
  );

  modport slave (
    input  acc_x, acc_y, acc_z,
    output filt_x, filt_y, dir, dir_valid, ready
  );
endinterface

// File: rtl/tilt_decoder.sv
// tilt_decoder: moving-average filter, hysteretic tilt classifier, debounce.
// TILT_ZCHECK_EN adds a Z window; negative filtered Z forces FLAT.
module tilt_decoder #(
  parameter int unsigned AVG_LOG2 = 2,
  parameter logic [11:0] THRESH   = 12'd300,
  parameter logic [11:0] HYST     = 12'd100,
  parameter logic [3:0]  HOLD     = 4'd3
) (
  input logic           clk_25,
  input logic           rst,
  tilt_decoder_if.slave bus
);
  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = 12 + AVG_LOG2;
`ifdef TILT_ZCHECK_EN
  localparam int unsigned NA = 3;
`else
  localparam int unsigned NA = 2;
`endif
  localparam logic [2:0] FLAT  = 3'd0;
  localparam logic [2:0] UP    = 3'd1;
  localparam logic [2:0] DOWN  = 3'd2;
  localparam logic [2:0] LEFT  = 3'd3;
  localparam logic [2:0] RIGHT = 3'd4;
  localparam logic [11:0] EXIT = THRESH - HYST;

  typedef enum logic [1:0] {
    FILL,
    TRACK,
    CONFIRM
  } state_t;

  state_t               state;
  logic signed [11:0]   win  [NA][N];
  logic signed [SW-1:0] sum  [NA];
  logic signed [11:0]   samp [NA];
  logic signed [11:0]   filt [NA];
  logic [4:0]           fill;
  logic [3:0]           cnt;
  logic [3:0]           n;
  logic [2:0]           dir;
  logic [2:0]           cand;
  logic [2:0]           cand_q;
  logic [2:0]           dom;
  logic [11:0]          mag_x;
  logic [11:0]          mag_y;
  logic [11:0]          m;
  logic                 x_dom;
  logic                 dir_valid;
  logic                 ready;

  always_comb begin
    samp[0] = bus.acc_x;
    samp[1] = bus.acc_y;
`ifdef TILT_ZCHECK_EN
    samp[2] = bus.acc_z;
`endif
    for (int a = 0; a < int'(NA); a++)
      filt[a] = 12'(sum[a] >>> AVG_LOG2);
  end

`ifndef TILT_ZCHECK_EN
  logic unused_z;
  assign unused_z = ^bus.acc_z;
`endif

  // Magnitude is unsigned so that -2048 maps to 2048.
  always_comb begin
    mag_x = filt[0][11] ? -filt[0] : filt[0];
    mag_y = filt[1][11] ? -filt[1] : filt[1];
    x_dom = mag_x >= mag_y;
    m     = x_dom ? mag_x : mag_y;
    dom   = x_dom ? (filt[0][11] ? LEFT : RIGHT)
                  : (filt[1][11] ? DOWN : UP);
    cand  = dir;
    unique case (1'b1)
      (m > THRESH): cand = dom;
      (m < EXIT):   cand = FLAT;
      default:      ;
    endcase
`ifdef TILT_ZCHECK_EN
    if (filt[2][11]) cand = FLAT;
`endif
    n = (cand == cand_q) ? cnt + 4'd1 : 4'd1;
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      fill      <= '0;
      cnt       <= '0;
      cand_q    <= FLAT;
      dir       <= FLAT;
      dir_valid <= 1'b0;
      ready     <= 1'b0;
      for (int a = 0; a < int'(NA); a++) begin
        sum[a] <= '0;
        for (int i = 0; i < int'(N); i++)
          win[a][i] <= '0;
      end
    end else begin
      for (int a = 0; a < int'(NA); a++) begin
        sum[a] <= sum[a] + SW'(samp[a]) - SW'(win[a][N-1]);
        win[a][0] <= samp[a];
        for (int i = 1; i < int'(N); i++)
          win[a][i] <= win[a][i-1];
      end
      cand_q    <= cand;
      dir_valid <= 1'b0;
      unique case (state)
        FILL: begin
          fill <= fill + 5'd1;
          if (fill + 5'd1 == 5'(N)) begin
            state <= TRACK;
            ready <= 1'b1;
          end
        end
        default: begin
          if (cand != dir) begin
            if (n == HOLD) begin
              dir       <= cand;
              dir_valid <= 1'b1;
              cnt       <= '0;
              state     <= TRACK;
            end else begin
              cnt   <= n;
              state <= CONFIRM;
            end
          end else begin
            cnt   <= '0;
            state <= TRACK;
          end
        end
      endcase
    end
  end

  assign bus.filt_x    = filt[0];
  assign bus.filt_y    = filt[1];
  assign bus.dir       = dir;
  assign bus.dir_valid = dir_valid;
  assign bus.ready     = ready;
endmodule

// File: tb/tb_tilt_decoder.sv
// tb_tilt_decoder: directed vectors plus a sample-history model checked
// every cycle on a default instance and an AVG_LOG2=0 instance.
module tb_tilt_decoder;
  logic clk_25 = 1'b0;
  logic rst = 1'b1;
  logic signed [11:0] ax = '0;
  logic signed [11:0] ay = '0;
  logic signed [11:0] az = '0;

  int vectors = 0;
  int miscompares = 0;

  always #20 clk_25 = ~clk_25;

  tilt_decoder_if b0 ();
  tilt_decoder_if b1 ();

  assign b0.acc_x = ax;
  assign b0.acc_y = ay;
  assign b0.acc_z = az;
  assign b1.acc_x = ax;
  assign b1.acc_y = ay;
  assign b1.acc_z = az;

  tilt_decoder u0 (
    .clk_25 (clk_25),
    .rst    (rst),
    .bus    (b0.slave)
  );

  tilt_decoder #(.AVG_LOG2(0)) u1 (
    .clk_25 (clk_25),
    .rst    (rst),
    .bus    (b1.slave)
  );

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: keep the raw sample history; filtered value is the floor
  // of the mean of the last 2^L samples (cleared history counts as 0).
  int hist [2][3][16];
  int nsamp [2];
  int mdir [2];
  int mdv [2];
  int streak [2];
  int scand [2];

  function automatic int lg(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int mfilt(input int k, input int a);
    int s;
    s = 0;
    for (int i = 0; i < (1 << lg(k)); i++) s += hist[k][a][i];
    return floor_div(s, 1 << lg(k));
  endfunction

  function automatic int classify(input int fx, input int fy,
                                  input int fz, input int d);
    int mx, my, m, dm, c;
    mx = (fx < 0) ? -fx : fx;
    my = (fy < 0) ? -fy : fy;
    if (mx >= my) begin
      m = mx;
      dm = (fx < 0) ? 3 : 4;
    end else begin
      m = my;
      dm = (fy < 0) ? 2 : 1;
    end
    if (m > 300) c = dm;
    else if (m < 200) c = 0;
    else c = d;
`ifdef TILT_ZCHECK_EN
    if (fz < 0) c = 0;
`else
    if (fz == 12345) c = c;
`endif
    return c;
  endfunction

  always @(posedge clk_25 or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int a = 0; a < 3; a++)
          for (int i = 0; i < 16; i++) hist[k][a][i] = 0;
        nsamp[k] = 0;
        mdir[k] = 0;
        mdv[k] = 0;
        streak[k] = 0;
        scand[k] = 0;
      end else begin
        int c;
        mdv[k] = 0;
        if (nsamp[k] < (1 << lg(k))) begin
          nsamp[k]++;
          streak[k] = 0;
        end else begin
          c = classify(mfilt(k, 0), mfilt(k, 1), mfilt(k, 2), mdir[k]);
          if (c != mdir[k]) begin
            if (streak[k] > 0 && c == scand[k]) streak[k]++;
            else streak[k] = 1;
            scand[k] = c;
            if (streak[k] == 3) begin
              mdir[k] = c;
              mdv[k] = 1;
              streak[k] = 0;
            end
          end else begin
            streak[k] = 0;
          end
        end
        for (int a = 0; a < 3; a++)
          for (int i = 15; i > 0; i--) hist[k][a][i] = hist[k][a][i-1];
        hist[k][0][0] = int'(ax);
        hist[k][1][0] = int'(ay);
        hist[k][2][0] = int'(az);
      end
    end
  end

  always @(negedge clk_25) begin
    chk("m0_filt_x", b0.filt_x, mfilt(0, 0));
    chk("m0_filt_y", b0.filt_y, mfilt(0, 1));
    chk("m0_dir", b0.dir, mdir[0]);
    chk("m0_dv", b0.dir_valid, mdv[0]);
    chk("m0_ready", b0.ready, (nsamp[0] >= 4) ? 1 : 0);
    chk("m1_filt_x", b1.filt_x, mfilt(1, 0));
    chk("m1_filt_y", b1.filt_y, mfilt(1, 1));
    chk("m1_dir", b1.dir, mdir[1]);
    chk("m1_dv", b1.dir_valid, mdv[1]);
    chk("m1_ready", b1.ready, (nsamp[1] >= 1) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk_25);
    #5;
    rst = 1'b0;
  endtask

  initial begin
    int p0, p1, pf;

    // Step to RIGHT from reset
    ax = 12'sd500;
    ay = 12'sd0;
    do_reset();
    chk("rst_dir", b0.dir, 0);
    chk("rst_ready", b0.ready, 0);
    chk("rst_dv", b0.dir_valid, 0);
    chk("rst_filt_x", b0.filt_x, 0);
    chk("rst_filt_y", b0.filt_y, 0);
    ticks(3);
    chk("ready_e3", b0.ready, 0);
    tick();
    chk("ready_e4", b0.ready, 1);
    chk("filt_x_e4", b0.filt_x, 500);
    chk("u1_dir_e4", b1.dir, 4);
    chk("u1_dv_e4", b1.dir_valid, 1);
    ticks(2);
    chk("dir_e6", b0.dir, 0);
    tick();
    chk("dir_e7", b0.dir, 4);
    chk("dv_e7", b0.dir_valid, 1);
    tick();
    chk("dv_e8", b0.dir_valid, 0);

    // Hysteresis band holds RIGHT, below exit commits FLAT
    ax = 12'sd250;
    ticks(8);
    chk("band_dir", b0.dir, 4);
    chk("band_filt", b0.filt_x, 250);
    ax = 12'sd150;
    ticks(5);
    chk("flat_e5", b0.dir, 4);
    tick();
    chk("flat_e6", b0.dir, 0);
    chk("flat_dv", b0.dir_valid, 1);

    // Tie goes to X, then Y takes over
    ax = -12'sd400;
    ay = 12'sd400;
    ticks(10);
    chk("tie_left", b0.dir, 3);
    ay = 12'sd600;
    ticks(10);
    chk("up", b0.dir, 1);
    ax = -12'sd500;
    ay = 12'sd0;
    ticks(10);
    chk("left", b0.dir, 3);

    // LEFT to RIGHT with no intermediate FLAT commit
    ax = 12'sd500;
    p0 = 0;
    pf = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b0.dir_valid) p0++;
      if (b0.dir_valid && b0.dir == 3'd0) pf++;
    end
    chk("lr_pulses", p0, 1);
    chk("lr_flat", pf, 0);
    chk("lr_dir", b0.dir, 4);

    // Alternating input never settles
    ax = 12'sd900;
    do_reset();
    p0 = 0;
    p1 = 0;
    for (int i = 0; i < 20; i++) begin
      ax = (i % 2 == 1) ? -12'sd900 : 12'sd900;
      tick();
      if (b0.dir_valid) p0++;
      if (b1.dir_valid) p1++;
    end
    chk("alt_u1_dir", b1.dir, 0);
    chk("alt_u1_pulses", p1, 0);
    chk("alt_u1_filt", b1.filt_x, -900);
    chk("alt_u0_pulses", p0, 0);

    // Reset while confirming
    ax = 12'sd500;
    ay = 12'sd0;
    do_reset();
    ticks(6);
    rst = 1'b1;
    #1;
    chk("mid_ready", b0.ready, 0);
    chk("mid_filt_x", b0.filt_x, 0);
    chk("mid_u1_dir", b1.dir, 0);
    chk("mid_dv", b0.dir_valid, 0);
    @(posedge clk_25);
    #5;
    rst = 1'b0;
    ticks(6);
    chk("re_e6", b0.dir, 0);
    tick();
    chk("re_e7", b0.dir, 4);
    chk("re_dv", b0.dir_valid, 1);

`ifdef TILT_ZCHECK_EN
    // Face-down board stays FLAT
    ax = 12'sd500;
    az = -12'sd1000;
    do_reset();
    ticks(12);
    chk("z_flat", b0.dir, 0);
    az = 12'sd1000;
    ticks(4);
    chk("z_e4", b0.dir, 0);
    tick();
    chk("z_e5", b0.dir, 4);
`endif

    ticks(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
